// File: rtl/bmp_sched_pkg.sv
// Shared types for the BMP/font placement command scheduler: opcodes,
// the 32-bit command word, scheduler FSM states and watchdog width.
package bmp_sched_pkg;

    localparam int WDOG_W = 16;
    localparam int CMD_W  = 32;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_ADD_IMG = 2'b01,
        OP_REM_IMG = 2'b10,
        OP_ADD_FNT = 2'b11
    } op_t;

    typedef struct packed {
        op_t        op;    // [31:30]
        logic [4:0] indx;  // [29:25]
        logic [5:0] fnt;   // [24:19]
        logic [9:0] x;     // [18:9]
        logic [8:0] y;     // [8:0]
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/bmp_cmd_fifo.sv
// Synchronous command FIFO of cmd_t; DEPTH must be a power of two so the
// read/write pointers wrap without extra logic.
module bmp_cmd_fifo
    import bmp_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  cmd_t                     i_data,
    input  logic                     i_pop,
    output cmd_t                     o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    cmd_t           r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Overflow/underflow requests are dropped here rather than trusted upstream.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/bmp_cmd_scheduler.sv
// Round-robin arbiter + command FIFO + issue FSM feeding the BMP/font placer.
// Optional BMP_SCHED_VBLANK_GATE_EN adds a vblank input gating IDLE->ISSUE.
module bmp_cmd_scheduler
    import bmp_sched_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_vld,
    output logic [NREQ-1:0]               req_rdy,
    input  logic [CMD_W*NREQ-1:0]         req_cmd,
    input  logic                          plc_busy,
    output logic                          add_img,
    output logic                          rem_img,
    output logic                          add_fnt,
    output logic [4:0]                    image_indx,
    output logic [5:0]                    fnt_indx,
    output logic [9:0]                    xloc,
    output logic [8:0]                    yloc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          sched_busy,
    output logic                          err_timeout,
    output sched_state_t                  dbg_state,
    input  logic                          clr_err
`ifdef BMP_SCHED_VBLANK_GATE_EN
    ,
    input  logic                          vblank
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Limit is TIMEOUT_CYC-1 because the count is zero in the first WAIT_DONE cycle.
    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(TIMEOUT_CYC - 1);

    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      w_grant;
    logic               w_found;
    int                 w_idx;
    cmd_t               w_sel;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_go;
    cmd_t               w_fifo_out;
    cmd_t               r_cmd;
    sched_state_t       r_state;
    sched_state_t       w_next;
    logic [WDOG_W-1:0]  r_wdog;
    logic               r_err;
    logic               w_err_set;

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_found && req_vld[w_idx]) begin
                w_found = 1'b1;
                w_grant = PW'(w_idx);
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        for (int g = 0; g < NREQ; g++) begin
            req_rdy[g] = w_found && (w_grant == PW'(g)) && !w_full;
        end
    end

    assign w_sel    = cmd_t'(req_cmd[CMD_W*w_grant +: CMD_W]);
    assign w_accept = |(req_vld & req_rdy);
    // NOPs complete the handshake but never occupy a FIFO slot.
    assign w_push   = w_accept && (w_sel.op != OP_NOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_grant == PW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
        end
    end

    bmp_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_sel),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_cnt)
    );

`ifdef BMP_SCHED_VBLANK_GATE_EN
    assign w_go = !w_empty && vblank;
`else
    assign w_go = !w_empty;
`endif

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_pop  = 1'b1;
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: w_next = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (plc_busy) begin
                    w_next = ST_WAIT_DONE;
                end else begin
                    w_err_set = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!plc_busy) begin
                    w_next = ST_IDLE;
                end else if (r_wdog >= WDOG_LIM) begin
                    w_err_set = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_wdog  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pop) r_cmd <= w_fifo_out;
            // Cleared while in WAIT_ACK so it reads zero on WAIT_DONE entry.
            if (r_state == ST_WAIT_ACK) begin
                r_wdog <= '0;
            end else if (r_state == ST_WAIT_DONE && r_wdog != '1) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (clr_err)        r_err <= 1'b0;
            else if (w_err_set) r_err <= 1'b1;
        end
    end

    assign add_img     = (r_state == ST_ISSUE) && (r_cmd.op == OP_ADD_IMG);
    assign rem_img     = (r_state == ST_ISSUE) && (r_cmd.op == OP_REM_IMG);
    assign add_fnt     = (r_state == ST_ISSUE) && (r_cmd.op == OP_ADD_FNT);
    assign image_indx  = r_cmd.indx;
    assign fnt_indx    = r_cmd.fnt;
    assign xloc        = r_cmd.x;
    assign yloc        = r_cmd.y;
    assign sched_busy  = !w_empty || (r_state != ST_IDLE);
    assign err_timeout = r_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_bmp_cmd_scheduler.sv
// Bench for bmp_cmd_scheduler: queue-fed requesters, behavioural placer,
// arbitration model and an issue-order scoreboard.
module tb_bmp_cmd_scheduler;
    import bmp_sched_pkg::*;

    localparam int NREQ  = 2;
    localparam int DEPTH = 8;
    localparam int TO    = 100;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_vld;
    logic [NREQ-1:0]     req_rdy;
    logic [32*NREQ-1:0]  req_cmd;
    logic                plc_busy;
    logic                add_img, rem_img, add_fnt;
    logic [4:0]          image_indx;
    logic [5:0]          fnt_indx;
    logic [9:0]          xloc;
    logic [8:0]          yloc;
    logic [CW-1:0]       fifo_cnt;
    logic                sched_busy;
    logic                err_timeout;
    sched_state_t        dbg_state;
    logic                clr_err = 1'b0;
`ifdef BMP_SCHED_VBLANK_GATE_EN
    logic                vblank = 1'b1;
`endif

    always #5 clk = ~clk;

    bmp_cmd_scheduler #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_cmd     (req_cmd),
        .plc_busy    (plc_busy),
        .add_img     (add_img),
        .rem_img     (rem_img),
        .add_fnt     (add_fnt),
        .image_indx  (image_indx),
        .fnt_indx    (fnt_indx),
        .xloc        (xloc),
        .yloc        (yloc),
        .fifo_cnt    (fifo_cnt),
        .sched_busy  (sched_busy),
        .err_timeout (err_timeout),
        .dbg_state   (dbg_state),
        .clr_err     (clr_err)
`ifdef BMP_SCHED_VBLANK_GATE_EN
        ,
        .vblank      (vblank)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int indx, input int fnt,
                                       input int x, input int y);
        return {2'(op), 5'(indx), 6'(fnt), 10'(x), 9'(y)};
    endfunction

    // ---------------- behavioural placer ----------------
    int  plc_mode = 0;   // 0 normal, 1 never busy, 2 always busy
    int  plc_len  = 40;
    bit  plc_rand = 1'b0;
    int  plc_left = 0;
    bit  pulse_seen = 1'b0;

    initial begin
        plc_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (plc_mode == 2) begin
                plc_left = 0;
                plc_busy = 1'b1;
            end else if (plc_mode == 1) begin
                plc_left = 0;
                plc_busy = 1'b0;
            end else if (pulse_seen && rst_n) begin
                plc_left = plc_rand ? int'($urandom_range(1, 6)) : plc_len;
                plc_busy = 1'b1;
            end else begin
                if (plc_left > 0) plc_left--;
                plc_busy = (plc_left > 0);
            end
        end
    end

    // ---------------- requester driver ----------------
    logic [31:0] feed_q0[$];
    logic [31:0] feed_q1[$];
    bit          acc0 = 1'b0;
    bit          acc1 = 1'b0;

    initial begin
        req_vld = '0;
        req_cmd = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                feed_q0.delete();
                feed_q1.delete();
            end else begin
                if (acc0 && feed_q0.size() > 0) void'(feed_q0.pop_front());
                if (acc1 && feed_q1.size() > 0) void'(feed_q1.pop_front());
            end
            req_vld[0]     = (feed_q0.size() > 0);
            req_cmd[31:0]  = (feed_q0.size() > 0) ? feed_q0[0] : 32'h0;
            req_vld[1]     = (feed_q1.size() > 0);
            req_cmd[63:32] = (feed_q1.size() > 0) ? feed_q1[0] : 32'h0;
        end
    end

    // ---------------- monitor: arbitration model + scoreboard ----------------
    logic [31:0] exp_q[$];
    int          acc_log[$];
    int          m_ptr = 0;
    int          m_g;
    int          m_a;
    int          acc_cyc = 0;
    int          pulse_cnt = 0;
    int          pulse_cyc = 0;
    logic [31:0] m_word;
    logic [31:0] m_obs;

    always @(negedge clk) begin
        pulse_seen = 1'b0;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            acc_log.delete();
            m_ptr = 0;
        end else begin
            if (req_vld != '0) begin
                m_g = -1;
                for (int i = 0; i < NREQ; i++)
                    if (m_g < 0 && req_vld[(m_ptr + i) % NREQ]) m_g = (m_ptr + i) % NREQ;
                if (req_rdy != '0) begin
                    chk("rdy_grant", 32'(req_rdy), 32'(1 << m_g));
                    m_ptr = (m_g + 1) % NREQ;
                    m_a = -1;
                    if (req_vld[0] && req_rdy[0]) begin acc0 = 1'b1; m_a = 0; end
                    else if (req_vld[1] && req_rdy[1]) begin acc1 = 1'b1; m_a = 1; end
                    if (m_a >= 0) begin
                        acc_log.push_back(m_a);
                        acc_cyc = cyc;
                        m_word = req_cmd[32*m_a +: 32];
                        if (m_word[31:30] != 2'b00) exp_q.push_back(m_word);
                    end
                end else begin
                    chk("rdy_only_when_full", 32'(fifo_cnt), DEPTH);
                end
            end
            if (add_img || rem_img || add_fnt) begin
                pulse_seen = 1'b1;
                pulse_cnt++;
                pulse_cyc = cyc;
                chk("pulse_onehot", 32'($countones({add_img, rem_img, add_fnt})), 1);
                m_obs = {(add_fnt ? 2'b11 : (rem_img ? 2'b10 : 2'b01)),
                         image_indx, fnt_indx, xloc, yloc};
                chk("pulse_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("issue_cmd", m_obs, exp_q.pop_front());
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick_n();
        @(negedge clk); #1;
    endtask

    task automatic reset_on();
        @(posedge clk); #2;
        rst_n = 1'b0;
    endtask

    task automatic reset_off();
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        reset_on();
        repeat (3) @(posedge clk);
        reset_off();
        tick_n();
    endtask

    task automatic wait_pulse(input string tag);
        int p = pulse_cnt;
        int k = 0;
        while (pulse_cnt == p && k < 60) begin tick_n(); k++; end
        chk(tag, 32'(pulse_cnt != p), 1);
    endtask

    task automatic wait_plc(input logic level, input int budget, input string tag);
        int k = 0;
        while (plc_busy !== level && k < budget) begin tick_n(); k++; end
        chk(tag, 32'(plc_busy), 32'(level));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (k < budget && !(feed_q0.size() == 0 && feed_q1.size() == 0 &&
               req_vld == '0 && !sched_busy && !plc_busy)) begin
            tick_n(); k++;
        end
        chk(tag, 32'(k < budget), 1);
        chk({tag, "_sb_drained"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish, got running expected finished");
        $fatal(1, "bench timeout");
    end

    // ---------------- tests ----------------
    int p0;
    int total;

    initial begin
        repeat (2) @(posedge clk);
        tick_n();
        chk("rst_pulses", 32'({add_img, rem_img, add_fnt}), 0);
        chk("rst_operands", {2'b00, image_indx, fnt_indx, xloc, yloc}, 0);
        chk("rst_status", 32'({fifo_cnt, sched_busy, err_timeout, req_rdy, dbg_state}), 0);
        reset_off();
        tick_n();

        // Single command: latency, pulse width, operands, sched_busy fall.
        plc_mode = 0; plc_len = 40; plc_rand = 1'b0;
        p0 = pulse_cnt;
        feed_q0.push_back(mk(1, 1, 0, 100, 50));
        wait_pulse("t1_pulse_seen");
        chk("t1_latency", 32'(pulse_cyc - acc_cyc), 2);
        chk("t1_add_img", 32'(add_img), 1);
        chk("t1_operands", {8'h0, image_indx, xloc, yloc}, {8'h0, 5'd1, 10'd100, 9'd50});
        tick_n();
        chk("t1_pulse_width", 32'(add_img), 0);
        wait_plc(1'b1, 5, "t1_plc_rise");
        wait_plc(1'b0, 60, "t1_plc_fall");
        chk("t1_sched_busy_hold", 32'(sched_busy), 1);
        tick_n();
        chk("t1_sched_busy_fall", 32'(sched_busy), 0);
        chk("t1_pulse_count", 32'(pulse_cnt - p0), 1);

        // Fairness: both requesters stream 4 commands each.
        do_reset();
        plc_len = 3;
        for (int i = 0; i < 4; i++) begin
            feed_q0.push_back(mk(1, i, i, 10 + i, 20 + i));
            feed_q1.push_back(mk(3, 8 + i, 30 + i, 200 + i, 100 + i));
        end
        wait_idle(400, "t2_idle");
        chk("t2_accept_count", 32'(acc_log.size()), 8);
        for (int i = 0; i < 8 && i < acc_log.size(); i++)
            chk("t2_rr_order", 32'(acc_log[i]), 32'(i % 2));

        // Full FIFO while the placer stays busy.
        do_reset();
        plc_mode = 2;
        feed_q0.push_back(mk(1, 2, 0, 5, 5));
        wait_pulse("t3_first_pulse");
        for (int i = 0; i < 9; i++) feed_q0.push_back(mk(3, i, i + 1, i * 3, i * 2));
        repeat (15) tick_n();
        for (int i = 0; i < 5; i++) begin
            chk("t3_fifo_full", 32'(fifo_cnt), DEPTH);
            chk("t3_rdy_low", 32'(req_rdy[0]), 0);
            tick_n();
        end
        chk("t3_ninth_pending", 32'(feed_q0.size()), 1);
        plc_mode = 0; plc_len = 2;
        wait_idle(300, "t3_idle");
        chk("t3_accept_count", 32'(acc_log.size()), 10);
        chk("t3_no_err", 32'(err_timeout), 0);

        // NOP filter.
        do_reset();
        p0 = pulse_cnt;
        feed_q1.push_back(mk(0, 3, 3, 3, 3));
        repeat (3) tick_n();
        chk("t4_nop_accepted", 32'(acc_log.size()), 1);
        chk("t4_fifo_cnt", 32'(fifo_cnt), 0);
        chk("t4_sched_busy", 32'(sched_busy), 0);
        repeat (10) tick_n();
        chk("t4_no_pulse", 32'(pulse_cnt - p0), 0);

        // Missing acknowledge, next command still issues, clear and priority.
        plc_mode = 1;
        feed_q0.push_back(mk(2, 4, 9, 300, 200));
        wait_pulse("t5_pulse");
        chk("t5_rem_img", 32'(rem_img), 1);
        tick_n();
        chk("t5_err_before", 32'(err_timeout), 0);
        tick_n();
        chk("t5_err_set", 32'(err_timeout), 1);
        plc_mode = 0; plc_len = 5;
        feed_q0.push_back(mk(1, 6, 0, 7, 8));
        wait_pulse("t5_next_pulse");
        chk("t5_next_add_img", 32'(add_img), 1);
        wait_idle(100, "t5_idle");
        chk("t5_err_sticky", 32'(err_timeout), 1);
        clr_err = 1'b1;
        tick_n();
        clr_err = 1'b0;
        chk("t5_err_clr", 32'(err_timeout), 0);
        plc_mode = 1;
        feed_q1.push_back(mk(3, 2, 2, 2, 2));
        wait_pulse("t5_prio_pulse");
        tick_n();
        clr_err = 1'b1;
        tick_n();
        clr_err = 1'b0;
        chk("t5_clr_priority", 32'(err_timeout), 0);
        plc_mode = 0;
        wait_idle(100, "t5_idle2");

        // Watchdog expiry, then reset with commands queued.
        do_reset();
        plc_mode = 2;
        feed_q0.push_back(mk(3, 1, 2, 3, 4));
        wait_pulse("t6_pulse");
        repeat (TO + 1) tick_n();
        chk("t6_err_before", 32'(err_timeout), 0);
        tick_n();
        chk("t6_err_at_timeout", 32'(err_timeout), 1);
        for (int i = 0; i < 4; i++) feed_q0.push_back(mk(1, 10 + i, 0, 40 + i, 60 + i));
        repeat (10) tick_n();
        chk("t6_queued", 32'(fifo_cnt), 3);
        p0 = pulse_cnt;
        reset_on();
        tick_n();
        chk("t6_rst_fifo", 32'(fifo_cnt), 0);
        chk("t6_rst_pulses", 32'({add_img, rem_img, add_fnt}), 0);
        chk("t6_rst_status", 32'({sched_busy, err_timeout}), 0);
        reset_off();
        repeat (10) tick_n();
        chk("t6_no_pulse_after_rst", 32'(pulse_cnt - p0), 0);
        chk("t6_fifo_after_rst", 32'(fifo_cnt), 0);
        plc_mode = 0;

        // Randomized traffic with random placer busy time.
        do_reset();
        plc_rand = 1'b1;
        total = 0;
        for (int b = 0; b < 8; b++) begin
            int n = int'($urandom_range(1, 9));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0) feed_q0.push_back($urandom);
                else                           feed_q1.push_back($urandom);
                total++;
            end
            repeat ($urandom_range(0, 20)) tick_n();
        end
        wait_idle(3000, "t7_idle");
        chk("t7_accept_count", 32'(acc_log.size()), 32'(total));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bmp_cmd_scheduler.md
Name: bmp_cmd_scheduler

Overview:
- Shares the 6-bit BMP/font placement engine among NREQ requesters, e.g. CPU MMIO and the sprite/game-logic engine.
- Flow: round-robin arbitration -> buffering in a command FIFO -> one command at a time issued as a single-cycle add_img/rem_img/add_fnt pulse with stable operands.
- Waits for the placer to finish before issuing the next command; a watchdog catches a hung placer.
- Sits between the requester fabric and the placement engine that writes videoMem.

Parameters:
- NREQ, 2: number of requesters (2..4).
- FIFO_DEPTH, 8: command FIFO entries; power of 2.
- TIMEOUT_CYC, 65535: maximum cycles a command may keep the placer busy before it is abandoned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_vld  in  NREQ  per-requester command valid.
- req_rdy  out  NREQ  per-requester accept; a command transfers when vld&rdy.
- req_cmd  in  32*NREQ  packed cmd_t per requester: op[31:30], indx[29:25], fnt[24:19], x[18:9], y[8:0].
- plc_busy  in  1  placer is not in its IDLE state; rises the cycle after a command pulse.
- add_img  out  1  one-cycle pulse to the placer.
- rem_img  out  1  one-cycle pulse to the placer.
- add_fnt  out  1  one-cycle pulse to the placer.
- image_indx  out  5  operand to the placer.
- fnt_indx  out  6  operand to the placer.
- xloc  out  10  operand to the placer.
- yloc  out  9  operand to the placer.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- sched_busy  out  1  FIFO non-empty or state != IDLE.
- err_timeout  out  1  sticky; set on watchdog expiry or missing acknowledge.
- clr_err  in  1  synchronous clear of err_timeout.

Behaviour:
- Reset values: all outputs 0; FIFO empty; arbiter pointer = requester 0; state = IDLE.
- Reset asserted mid-command drops all queued and in-flight commands. The placer is not notified.
- Op encoding: 00 NOP, 01 ADD_IMG, 10 REM_IMG, 11 ADD_FNT. A NOP is accepted (rdy honoured) but never enqueued.
- Arbiter:
  - Each cycle, grants the first requester with vld, searching from ptr.
  - req_rdy[g] = (g == grant) & !full, where full is registered. At most one req_rdy is high per cycle.
  - After an accept, ptr = grant+1 mod NREQ. With no accept, ptr is unchanged.
- FIFO:
  - Push on accept of a non-NOP command; pop only on the IDLE->ISSUE transition.
  - Push and pop in the same cycle are allowed when not full; fifo_cnt is then unchanged.
  - When full, no push occurs even if a pop happens in that cycle.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE: if the FIFO is non-empty, pop into the operand register and go to ISSUE.
  - ISSUE: assert exactly one of add_img/rem_img/add_fnt for one cycle, selected by op; go to WAIT_ACK.
  - WAIT_ACK: if plc_busy = 1, go to WAIT_DONE. Otherwise set err_timeout and go to IDLE (no acknowledge).
  - WAIT_DONE: when plc_busy = 0, go to IDLE. If the watchdog reaches TIMEOUT_CYC, set err_timeout and go to IDLE.
- Watchdog: 16-bit counter, cleared on entering WAIT_DONE and saturating.
- Operand outputs (image_indx, fnt_indx, xloc, yloc) are loaded on pop and held stable until the next pop.
  - For a REM_IMG, fnt_indx is don't-care and is driven from the command.
- Latency: when IDLE with the FIFO empty, an accept in cycle N gives the pulse in cycle N+2. Back-to-back issue gap = placer busy time + 2 cycles.
- clr_err takes priority over a simultaneous error set.

Optional Feature:
- Macro BMP_SCHED_VBLANK_GATE_EN.
- Defined: adds input vblank (1 bit). IDLE leaves for ISSUE only when vblank = 1, so placement never tears the visible frame. A command already started completes regardless of vblank.
- Undefined: the port is absent and IDLE->ISSUE depends only on FIFO non-empty.

Decomposition:
- Package bmp_sched_pkg holds:
  - op_t enum (NOP, ADD_IMG, REM_IMG, ADD_FNT).
  - cmd_t packed struct (32 bits, layout as in the req_cmd port).
  - sched_state_t enum.
  - Watchdog width constant.
- Sub-module bmp_cmd_fifo: synchronous FIFO of cmd_t, parameter DEPTH, providing push, pop, full, empty and count.
- The arbiter and FSM stay in the top module.

Test Plan:
- Single command: req0 sends ADD_IMG, indx=1, x=100, y=50, while idle. Required: add_img high for exactly 1 cycle at N+2 with image_indx=1, xloc=100, yloc=50. plc_busy is modelled as 40 cycles; sched_busy falls 1 cycle after plc_busy falls.
- Fairness: both requesters hold vld continuously with 4 commands each. Required: enqueue order r0,r1,r0,r1,... and issue order identical.
- Full FIFO: 9 ADD_FNT pushed while plc_busy is held high. Required: fifo_cnt=8, the 9th req_rdy stays 0 until the first pop, and no command is lost or reordered.
- NOP filter: req1 sends op=00. Required: accepted (rdy=1), fifo_cnt unchanged, no pulse issued.
- Missing acknowledge: plc_busy stuck at 0 after a REM_IMG pulse. Required: err_timeout=1 on the next cycle and the next command still issues. clr_err then clears the flag.
- Watchdog and reset: plc_busy stuck at 1 with TIMEOUT_CYC=100 gives err_timeout at 100 cycles. Then rst_n asserted with 3 commands queued gives fifo_cnt=0 and all pulses 0.
